mem_responder: RTL and testbench

//  Memory-side responder for the CPU hello/ack bus (cpu_hello_o/cpu_ack_i, cpu_we_o, cpu_addr_o, cpu_data_o/i).

---
 rtl/mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the CPU hello/ack bus. Each request is latched
//   on the IDLE edge where hello_i is seen. The block then waits WAIT_CYCLES
//   wait states and spends one ACCESS cycle on the on-chip RAM. It completes
//   with a four-phase ack: ack_o stays high until hello_i drops.
//
// Ports
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   hello_i  in   1       request valid, held until ack seen
//   we_i     in   1       1 = write, 0 = read (sampled with hello_i)
//   addr_i   in   ADDR_W  word address (sampled with hello_i)
//   data_i   in   DATA_W  write data (sampled with hello_i)
//   data_o   out  DATA_W  read data, held until the next read completes
//   ack_o    out  1       transaction complete, high until hello_i drops
//   busy_o   out  1       high in any state other than IDLE
//   led_o    out  16      memory-mapped LED register
//
// Build option
//   MEM_RESP_LED_EN : maps address all-ones to a 16-bit LED register.
//                     When it is undefined, led_o is tied to 0 and all-ones
//                     is an ordinary (or out-of-range) RAM address.
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for hello_i; latches request on it
//   S_WAIT   | counting wait states; hello_i low aborts
//   S_ACCESS | single RAM / LED access cycle
//   S_ACK    | ack_o high until hello_i drops

module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hello_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic [15:0]       led_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic ack_d, busy_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic              led_hit;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0]  idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The wait counter is a down-counter. WAIT is left on
  // the edge where the counter reads 1, so WAIT lasts exactly WAIT_CYCLES
  // cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hello_i) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!hello_i) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_ACK;
      S_ACK: begin
        if (!hello_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. It is taken from the next state so that the registered
  // flags line up with the state they describe.
  always_comb begin
    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o  <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      ack_o  <= ack_d;
      busy_o <= busy_d;
    end
  end

  // Request latch: later changes on we_i/addr_i/data_i are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (state_q == S_IDLE && hello_i) begin
      we_q   <= we_i;
      addr_q <= addr_i;
      data_q <= data_i;
    end
  end

  assign in_range = (32'(addr_q) < 32'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];

`ifdef MEM_RESP_LED_EN
  logic [15:0] led_q;

  assign led_hit = (addr_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 16'd0;
    end else if (state_q == S_ACCESS && we_q && led_hit) begin
      led_q <= 16'(data_q);
    end
  end

  assign led_o = led_q;

  always_comb begin
    rd_data = '0;
    if (led_hit)       rd_data = DATA_W'(led_q);
    else if (in_range) rd_data = mem[idx];
  end
`else
  assign led_hit = 1'b0;
  assign led_o   = 16'd0;

  always_comb begin
    rd_data = '0;
    if (in_range) rd_data = mem[idx];
  end
`endif

  // RAM is not reset. Out-of-range writes are simply dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && we_q && in_range && !led_hit) begin
      mem[idx] <= data_q;
    end
  end

  // Read data only changes when a read completes its ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= '0;
    end else if (state_q == S_ACCESS && !we_q) begin
      data_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives hello/ack transactions into mem_responder (DEPTH=128,
//   WAIT_CYCLES=2). A transaction-level model holds the expected
//   ack/busy/data/led values for every cycle; a single compare process
//   checks the DUT against them on each falling edge.

module tb_mem_responder;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 128;
  localparam int W     = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hello_i = 1'b0;
  logic          we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          ack_o;
  logic          busy_o;
  logic [15:0]   led_o;

  mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hello_i(hello_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .ack_o(ack_o), .busy_o(busy_o), .led_o(led_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mem_m [256];
  logic [15:0] led_m = 16'd0;
  logic        exp_ack = 1'b0;
  logic        exp_busy = 1'b0;
  logic [7:0]  exp_data = 8'd0;
  logic [15:0] exp_led = 16'd0;
  bit          chk_en = 1'b0;
  logic [7:0]  last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
`ifdef MEM_RESP_LED_EN
    if (a == 8'hFF) return led_m[7:0];
`endif
    if (int'(a) >= DEPTH) return 8'h00;
    return mem_m[a];
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
`ifdef MEM_RESP_LED_EN
    if (a == 8'hFF) begin
      led_m = {8'h00, d};
      return;
    end
`endif
    if (int'(a) < DEPTH) mem_m[a] = d;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack_o", 32'(ack_o), 32'(exp_ack));
      chk("busy_o", 32'(busy_o), 32'(exp_busy));
      chk("data_o", 32'(data_o), 32'(exp_data));
      chk("led_o", 32'(led_o), 32'(exp_led));
    end
  end

  // abort_at = j (1..W): hello_i is sampled low on the j-th WAIT edge.
  task automatic txn(input bit we, input logic [7:0] a, input logic [7:0] d,
                     input int abort_at, input int hold);
    @(negedge clk);
    hello_i = 1'b1; we_i = we; addr_i = a; data_i = d;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    we_i = 1'($urandom); addr_i = 8'($urandom); data_i = 8'($urandom);
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      @(negedge clk);
      hello_i = 1'b0;
      @(posedge clk); #1;
      exp_busy = 1'b0;
    end else begin
      repeat (W) @(posedge clk);
      @(posedge clk); #1;
      exp_ack = 1'b1;
      if (we) model_write(a, d);
      else    exp_data = model_read(a);
      exp_led = led_m;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      last_rd = data_o;
      hello_i = 1'b0;
      @(posedge clk); #1;
      exp_ack  = 1'b0;
      exp_busy = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] a;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(ack_o), 32'd0);
    chk("reset_data", 32'(data_o), 32'd0);
    rst_n = 1'b1;

    // Fill every RAM word so all later reads are defined
    for (int i = 0; i < DEPTH; i++) txn(1'b1, 8'(i), 8'($urandom), 0, 0);

    // Randomized traffic, including out-of-range, all-ones address and aborts
    for (int i = 0; i < 200; i++) begin
      a = (($urandom % 8) == 0) ? 8'hFF : 8'($urandom);
      txn(1'($urandom), a, 8'($urandom),
          (($urandom % 5) == 0) ? int'($urandom_range(1, W)) : 0,
          int'($urandom_range(0, 3)));
    end

    // Write then read back at 0x10
    txn(1'b1, 8'h10, 8'h5A, 0, 0);
    txn(1'b0, 8'h10, 8'h00, 0, 0);
    chk("t1_read_0x10", 32'(last_rd), 32'h5A);

    // Hold hello_i 5 cycles after ack, then release
    txn(1'b0, 8'h10, 8'h00, 0, 5);
    chk("t2_hold_data", 32'(last_rd), 32'h5A);
    @(negedge clk);
    chk("t2_busy_after", 32'(busy_o), 32'd0);

    // Aborted writes at both possible wait positions leave RAM alone
    txn(1'b1, 8'h20, 8'h11, 0, 0);
    txn(1'b1, 8'h20, 8'hFF, 1, 0);
    txn(1'b1, 8'h20, 8'hEE, 2, 0);
    txn(1'b0, 8'h20, 8'h00, 0, 0);
    chk("t3_abort_keep", 32'(last_rd), 32'h11);

    // Reset in WAIT of a write: outputs clear at once, write not performed
    txn(1'b1, 8'h05, 8'h44, 0, 0);
    txn(1'b0, 8'h10, 8'h00, 0, 0);
    @(negedge clk);
    hello_i = 1'b1; we_i = 1'b1; addr_i = 8'h05; data_i = 8'h33;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    hello_i = 1'b0;
    exp_ack = 1'b0; exp_busy = 1'b0; exp_data = 8'h00; exp_led = 16'd0; led_m = 16'd0;
    #1;
    chk("t4_rst_busy", 32'(busy_o), 32'd0);
    chk("t4_rst_data", 32'(data_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 8'h05, 8'h00, 0, 0);
    chk("t4_0x05_kept", 32'(last_rd), 32'h44);

    // Out-of-range write is acked and dropped; read returns 0
    txn(1'b1, 8'h90, 8'h77, 0, 0);
    txn(1'b0, 8'h90, 8'h00, 0, 0);
    chk("t5_oor_read", 32'(last_rd), 32'h00);

    // LED register at address all-ones
    txn(1'b0, 8'h10, 8'h00, 0, 0);
    txn(1'b1, 8'hFF, 8'hC3, 0, 0);
    txn(1'b0, 8'hFF, 8'h00, 0, 0);
`ifdef MEM_RESP_LED_EN
    chk("t6_led_reg", 32'(led_o), 32'h00C3);
    chk("t6_led_read", 32'(last_rd), 32'hC3);
`else
    chk("t6_led_zero", 32'(led_o), 32'h0000);
    chk("t6_ff_read", 32'(last_rd), 32'h00);
`endif

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
